// File: rtl/eth_rst_seq_pkg.sv
// Shared types and default timing for the Ethernet reset sequencer.
package eth_rst_seq_pkg;

   typedef enum logic [1:0] {
      S_PHY_RST   = 2'd0,
      S_PHY_WAIT  = 2'd1,
      S_LINK_WAIT = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   localparam int unsigned DEF_PHY_RST_CYC  = 1_250_000;
   localparam int unsigned DEF_PHY_WAIT_CYC = 625_000;
   localparam int unsigned DEF_DEBOUNCE_CYC = 125_000;
   localparam int unsigned DEF_LINK_REQ     = 1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/link_debounce.sv
// Two-flop synchroniser followed by a debounce counter for an async status pin.
module link_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 125_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);

   logic          sync_meta;
   logic          din_s;
   logic [DW-1:0] dcnt;

   // Synchronise the pin, then only follow it after it has differed from dout for DEBOUNCE_CYC cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         din_s     <= 1'b0;
         dcnt      <= '0;
         dout      <= 1'b0;
      end else begin
         sync_meta <= din;
         din_s     <= sync_meta;
         if (din_s == dout) begin
            dcnt <= '0;
         end else if (dcnt == D_LAST) begin
            dout <= din_s;
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/eth_rst_seq.sv
// Sequences PHY reset, PHY boot wait and link qualification before releasing the MAC/UDP datapath.
module eth_rst_seq
   import eth_rst_seq_pkg::*;
#(
   parameter int unsigned PHY_RST_CYC   = DEF_PHY_RST_CYC,
   parameter int unsigned PHY_WAIT_CYC  = DEF_PHY_WAIT_CYC,
   parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
   parameter int unsigned LINK_REQUIRED = DEF_LINK_REQ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic soft_rst_req,
   input  logic link_raw,
   output logic phy_rst_n,
   output logic mac_rst_n,
   output logic link_up,
   output logic ready
);

   localparam int unsigned CNT_MAX = max_u(PHY_RST_CYC, PHY_WAIT_CYC);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PHY_WAIT_CYC - 1);
   localparam bit LINK_REQ = (LINK_REQUIRED != 0);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   link_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_link_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (link_raw),
      .dout (link_up)
   );

   // State, shared counter and outputs; outputs are decoded from the next state so they change with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_PHY_RST;
         cnt       <= '0;
         phy_rst_n <= 1'b0;
         mac_rst_n <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         phy_rst_n <= (state_next != S_PHY_RST);
         mac_rst_n <= (state_next == S_RUN);
      end
   end

   // Next-state and counter logic; a soft reset request overrides every other transition.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         S_PHY_RST: begin
            if (cnt == RST_LAST) begin
               cnt_next   = '0;
               state_next = S_PHY_WAIT;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         S_PHY_WAIT: begin
            if (cnt == WAIT_LAST) begin
               cnt_next   = '0;
               state_next = LINK_REQ ? S_LINK_WAIT : S_RUN;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         S_LINK_WAIT: begin
            cnt_next = '0;
            if (link_up) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            cnt_next = '0;
            if (LINK_REQ && !link_up) begin
               state_next = S_LINK_WAIT;
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = S_PHY_RST;
         end
      endcase
      if (soft_rst_req) begin
         cnt_next   = '0;
         state_next = S_PHY_RST;
      end
   end

   assign ready = mac_rst_n;

endmodule
